// File: rtl/i2c_axi_lite_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_axi_lite_arbiter
//
// Two-master AXI-Lite arbiter in front of the I2C controller's register port.
// One whole transaction (address, data, response) is granted at a time and at
// most one transaction is outstanding downstream, so register sequences from
// the two masters never interleave inside a transaction.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*/ar*/r* upstream channels, packed per master (lane i = master i)
//   m_axi_aw*/w*/b*/ar*/r* single downstream port to the I2C controller
//   grant                  one-hot current owner, 00 while idle
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH  bus widths
//   FIXED_PRIO              0 = round-robin, 1 = master 0 always wins
// ---------------------------------------------------------------------------
module i2c_axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic [2*ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [1:0]              s_axi_awvalid,
    output logic [1:0]              s_axi_awready,
    input  logic [2*DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [1:0]              s_axi_wvalid,
    output logic [1:0]              s_axi_wready,
    output logic [3:0]              s_axi_bresp,
    output logic [1:0]              s_axi_bvalid,
    input  logic [1:0]              s_axi_bready,
    input  logic [2*ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [1:0]              s_axi_arvalid,
    output logic [1:0]              s_axi_arready,
    output logic [2*DATA_WIDTH-1:0] s_axi_rdata,
    output logic [3:0]              s_axi_rresp,
    output logic [1:0]              s_axi_rvalid,
    input  logic [1:0]              s_axi_rready,

    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,

    output logic [1:0]              grant
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_RESP
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;        // index of the master served most recently
    logic       aw_done_q, aw_done_d;  // AW already forwarded in this write
    logic       w_done_q, w_done_d;    // W already forwarded in this write

    logic [1:0] req;
    logic       g;                     // index of the granted master
    logic       win;                   // arbitration winner while idle
    logic       aw_hs, w_hs;

    // Places a single-bit value on lane sel of a two-lane bus; the other lane is 0.
    function automatic logic [1:0] lane(input logic sel, input logic b);
        return sel ? {b, 1'b0} : {1'b0, b};
    endfunction

    assign req   = s_axi_awvalid | s_axi_arvalid;
    assign g     = grant_q[1];
    assign grant = grant_q;

    // Round-robin prefers the master that was not served last; fixed priority
    // falls back to master 1 only when master 0 is silent.
    always_comb begin
        if (FIXED_PRIO != 0) begin
            win = ~req[0];
        end else begin
            win = req[~last_q] ? ~last_q : last_q;
        end
    end

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;

        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bresp   = '0;
        s_axi_bvalid  = '0;
        s_axi_arready = '0;
        s_axi_rdata   = '0;
        s_axi_rresp   = '0;
        s_axi_rvalid  = '0;

        m_axi_awaddr  = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    // A master offering both a write and a read is given the write.
                    state_d = s_axi_awvalid[win] ? WR_ADDR : RD_ADDR;
                end
            end

            WR_ADDR: begin
                // AW and W may finish in either order; the done flags stop a
                // channel that already handshook from being offered again.
                m_axi_awaddr  = g ? s_axi_awaddr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                                  : s_axi_awaddr[ADDR_WIDTH-1:0];
                m_axi_wdata   = g ? s_axi_wdata[2*DATA_WIDTH-1 -: DATA_WIDTH]
                                  : s_axi_wdata[DATA_WIDTH-1:0];
                m_axi_awvalid = s_axi_awvalid[g] & ~aw_done_q;
                m_axi_wvalid  = s_axi_wvalid[g] & ~w_done_q;
                s_axi_awready = lane(g, m_axi_awready & ~aw_done_q);
                s_axi_wready  = lane(g, m_axi_wready & ~w_done_q);
                aw_hs         = m_axi_awvalid & m_axi_awready;
                w_hs          = m_axi_wvalid & m_axi_wready;
                aw_done_d     = aw_done_q | aw_hs;
                w_done_d      = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            WR_RESP: begin
                m_axi_bready = s_axi_bready[g];
                s_axi_bvalid = lane(g, m_axi_bvalid);
                s_axi_bresp  = g ? {m_axi_bresp, 2'b00} : {2'b00, m_axi_bresp};
                if (m_axi_bvalid && m_axi_bready) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = g;
                end
            end

            RD_ADDR: begin
                m_axi_araddr  = g ? s_axi_araddr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                                  : s_axi_araddr[ADDR_WIDTH-1:0];
                m_axi_arvalid = s_axi_arvalid[g];
                s_axi_arready = lane(g, m_axi_arready);
                if (m_axi_arvalid && m_axi_arready) begin
                    state_d = RD_RESP;
                end
            end

            RD_RESP: begin
                m_axi_rready = s_axi_rready[g];
                s_axi_rvalid = lane(g, m_axi_rvalid);
                s_axi_rdata  = g ? {m_axi_rdata, {DATA_WIDTH{1'b0}}}
                                 : {{DATA_WIDTH{1'b0}}, m_axi_rdata};
                s_axi_rresp  = g ? {m_axi_rresp, 2'b00} : {2'b00, m_axi_rresp};
                if (m_axi_rvalid && m_axi_rready) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = g;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order blocks are evaluated in.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_i2c_axi_lite_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_axi_lite_arbiter
//
// Two arbiter instances: g_inst[0] round-robin, g_inst[1] fixed priority.
// Each drives a small register-file slave that stands in for the I2C
// controller (256 words indexed by address[7:0], OKAY responses).
// Master-side signals are per instance [k] and per master [m].
// ---------------------------------------------------------------------------
module tb_i2c_axi_lite_arbiter;

    logic aclk = 1'b0;
    logic aresetn;

    always #5 aclk = ~aclk;

    // master-side stimulus, [instance][master]
    logic        awv [2][2];
    logic        wv  [2][2];
    logic        bry [2][2];
    logic        arv [2][2];
    logic        rry [2][2];
    logic [31:0] awa [2][2];
    logic [31:0] wd  [2][2];
    logic [31:0] ara [2][2];

    // upstream outputs of each instance
    logic [1:0]  awr   [2];
    logic [1:0]  wr    [2];
    logic [1:0]  bv    [2];
    logic [3:0]  bresp [2];
    logic [1:0]  arr   [2];
    logic [1:0]  rv    [2];
    logic [3:0]  rresp [2];
    logic [63:0] rdata [2];
    logic [1:0]  grant [2];

    int total = 0;
    int bad   = 0;
    int seq_ctr = 0;
    int bv1_cnt = 0;

    for (genvar k = 0; k < 2; k++) begin : g_inst
        logic [63:0] s_awaddr, s_wdata, s_araddr;
        logic [1:0]  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
        logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
        logic        m_awvalid, m_awready, m_wvalid, m_wready;
        logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
        logic [1:0]  m_bresp, m_rresp;

        assign s_awaddr  = {awa[k][1], awa[k][0]};
        assign s_wdata   = {wd[k][1], wd[k][0]};
        assign s_araddr  = {ara[k][1], ara[k][0]};
        assign s_awvalid = {awv[k][1], awv[k][0]};
        assign s_wvalid  = {wv[k][1], wv[k][0]};
        assign s_bready  = {bry[k][1], bry[k][0]};
        assign s_arvalid = {arv[k][1], arv[k][0]};
        assign s_rready  = {rry[k][1], rry[k][0]};

        i2c_axi_lite_arbiter #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .FIXED_PRIO(k)
        ) dut (
            .aclk          (aclk),
            .aresetn       (aresetn),
            .s_axi_awaddr  (s_awaddr),
            .s_axi_awvalid (s_awvalid),
            .s_axi_awready (awr[k]),
            .s_axi_wdata   (s_wdata),
            .s_axi_wvalid  (s_wvalid),
            .s_axi_wready  (wr[k]),
            .s_axi_bresp   (bresp[k]),
            .s_axi_bvalid  (bv[k]),
            .s_axi_bready  (s_bready),
            .s_axi_araddr  (s_araddr),
            .s_axi_arvalid (s_arvalid),
            .s_axi_arready (arr[k]),
            .s_axi_rdata   (rdata[k]),
            .s_axi_rresp   (rresp[k]),
            .s_axi_rvalid  (rv[k]),
            .s_axi_rready  (s_rready),
            .m_axi_awaddr  (m_awaddr),
            .m_axi_awvalid (m_awvalid),
            .m_axi_awready (m_awready),
            .m_axi_wdata   (m_wdata),
            .m_axi_wvalid  (m_wvalid),
            .m_axi_wready  (m_wready),
            .m_axi_bresp   (m_bresp),
            .m_axi_bvalid  (m_bvalid),
            .m_axi_bready  (m_bready),
            .m_axi_araddr  (m_araddr),
            .m_axi_arvalid (m_arvalid),
            .m_axi_arready (m_arready),
            .m_axi_rdata   (m_rdata),
            .m_axi_rresp   (m_rresp),
            .m_axi_rvalid  (m_rvalid),
            .m_axi_rready  (m_rready),
            .grant         (grant[k])
        );

        // register-file slave
        logic [31:0] mem [256];
        logic        have_aw, have_w, bvalid_q, rvalid_q;
        logic [7:0]  aw_idx;
        logic [31:0] w_dat, rdata_q, last_awaddr, last_wdata;
        int          aw_hs_cnt;

        assign m_awready = ~have_aw & ~bvalid_q;
        assign m_wready  = ~have_w & ~bvalid_q;
        assign m_arready = ~rvalid_q;
        assign m_bvalid  = bvalid_q;
        assign m_bresp   = 2'b00;
        assign m_rvalid  = rvalid_q;
        assign m_rdata   = rdata_q;
        assign m_rresp   = 2'b00;

        always @(posedge aclk) begin
            if (aresetn && have_aw && have_w) mem[aw_idx] <= w_dat;
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                have_aw     <= 1'b0;
                have_w      <= 1'b0;
                bvalid_q    <= 1'b0;
                rvalid_q    <= 1'b0;
                aw_idx      <= '0;
                w_dat       <= '0;
                rdata_q     <= '0;
                last_awaddr <= '0;
                last_wdata  <= '0;
                aw_hs_cnt   <= 0;
            end else begin
                if (m_awvalid && m_awready) begin
                    have_aw     <= 1'b1;
                    aw_idx      <= m_awaddr[7:0];
                    last_awaddr <= m_awaddr;
                    aw_hs_cnt   <= aw_hs_cnt + 1;
                end
                if (m_wvalid && m_wready) begin
                    have_w     <= 1'b1;
                    w_dat      <= m_wdata;
                    last_wdata <= m_wdata;
                end
                if (have_aw && have_w) begin
                    have_aw  <= 1'b0;
                    have_w   <= 1'b0;
                    bvalid_q <= 1'b1;
                end
                if (bvalid_q && m_bready) bvalid_q <= 1'b0;
                if (m_arvalid && m_arready) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= mem[m_araddr[7:0]];
                end else if (rvalid_q && m_rready) begin
                    rvalid_q <= 1'b0;
                end
            end
        end
    end

    // counts cycles in which master 1 of instance 0 sees a write response
    always @(negedge aclk) begin
        if (bv[0][1]) bv1_cnt <= bv1_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_up"}, {52'd0, awr[0], wr[0], bv[0], arr[0], rv[0], grant[0]}, '0);
        check({tag, "_rdata"}, rdata[0], '0);
        check({tag, "_resp"}, {56'd0, bresp[0], rresp[0]}, '0);
        check({tag, "_dn"}, {59'd0, g_inst[0].m_awvalid, g_inst[0].m_wvalid, g_inst[0].m_bready,
                             g_inst[0].m_arvalid, g_inst[0].m_rready}, '0);
    endtask

    // One write from master m of instance k. W is raised w_delay cycles after AW,
    // bready b_delay cycles after start. gseen collects grant over the wait.
    task automatic do_write(input int k, input int m, input logic [31:0] a, input logic [31:0] d,
                            input int w_delay, input int b_delay,
                            output int seq, output logic [1:0] resp, output logic [1:0] gseen);
        int   n;
        logic a_hs, w_hs, b_hs, w_ok, b_ok;
        n = 0; w_ok = 1'b0; b_ok = 1'b0; gseen = '0; resp = 2'b11;
        awa[k][m] = a;
        wd[k][m]  = d;
        awv[k][m] = 1'b1;
        wv[k][m]  = (w_delay == 0);
        bry[k][m] = (b_delay == 0);
        while (!b_ok && n < 400) begin
            @(negedge aclk);
            a_hs  = awv[k][m] & awr[k][m];
            w_hs  = wv[k][m] & wr[k][m];
            b_hs  = bry[k][m] & bv[k][m];
            gseen = gseen | grant[k];
            if (b_hs) resp = bresp[k][2*m +: 2];
            @(posedge aclk);
            #1;
            n++;
            if (a_hs) awv[k][m] = 1'b0;
            if (w_hs) begin wv[k][m] = 1'b0; w_ok = 1'b1; end
            if (!w_ok && n >= w_delay) wv[k][m] = 1'b1;
            if (n >= b_delay) bry[k][m] = 1'b1;
            if (b_hs) begin b_ok = 1'b1; bry[k][m] = 1'b0; end
        end
        check($sformatf("wr_done_k%0d_m%0d_a%0h", k, m, a), {63'd0, b_ok}, 64'd1);
        seq = seq_ctr;
        seq_ctr++;
    endtask

    task automatic do_read(input int k, input int m, input logic [31:0] a,
                           output logic [31:0] d, output int seq, output logic [1:0] gseen);
        int   n;
        logic a_hs, r_hs, r_ok;
        n = 0; r_ok = 1'b0; gseen = '0; d = '1;
        ara[k][m] = a;
        arv[k][m] = 1'b1;
        rry[k][m] = 1'b1;
        while (!r_ok && n < 400) begin
            @(negedge aclk);
            a_hs  = arv[k][m] & arr[k][m];
            r_hs  = rry[k][m] & rv[k][m];
            gseen = gseen | grant[k];
            if (r_hs) d = rdata[k][32*m +: 32];
            @(posedge aclk);
            #1;
            n++;
            if (a_hs) arv[k][m] = 1'b0;
            if (r_hs) begin r_ok = 1'b1; rry[k][m] = 1'b0; end
        end
        check($sformatf("rd_done_k%0d_m%0d_a%0h", k, m, a), {63'd0, r_ok}, 64'd1);
        seq = seq_ctr;
        seq_ctr++;
    endtask

    initial begin
        int          s0, s1, n, aw0, bvc0;
        logic [1:0]  r0, r1, gs0, gs1;
        logic [31:0] d0, d1;
        logic        hs;

        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                awv[k][m] = 1'b0; wv[k][m] = 1'b0; bry[k][m] = 1'b0;
                arv[k][m] = 1'b0; rry[k][m] = 1'b0;
                awa[k][m] = '0;   wd[k][m]  = '0;  ara[k][m] = '0;
            end
        end

        // reset
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_idle("reset");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // single write from M0
        aw0  = g_inst[0].aw_hs_cnt;
        bvc0 = bv1_cnt;
        do_write(0, 0, 32'h08, 32'hA5, 0, 0, s0, r0, gs0);
        check("w1_awaddr", {32'd0, g_inst[0].last_awaddr}, 64'h08);
        check("w1_wdata", {32'd0, g_inst[0].last_wdata}, 64'hA5);
        check("w1_bresp", {62'd0, r0}, 64'd0);
        check("w1_grant_during", {62'd0, gs0}, 64'b01);
        check("w1_grant_after", {62'd0, grant[0]}, 64'b00);
        check("w1_bvalid_m1", bv1_cnt - bvc0, 64'd0);
        check("w1_aw_count", g_inst[0].aw_hs_cnt - aw0, 64'd1);

        // preload read targets; M0 finishes last so it is the last grant
        do_write(0, 1, 32'h14, 32'h22, 0, 0, s0, r0, gs0);
        check("pre_m1_grant", {62'd0, gs0}, 64'b10);
        do_write(0, 0, 32'h10, 32'h11, 0, 0, s0, r0, gs0);

        // simultaneous reads under round-robin: M1 goes first
        fork
            do_read(0, 0, 32'h10, d0, s0, gs0);
            do_read(0, 1, 32'h14, d1, s1, gs1);
        join
        check("rr_m1_first", {63'd0, s1 < s0}, 64'd1);
        check("rr_m0_data", {32'd0, d0}, 64'h11);
        check("rr_m1_data", {32'd0, d1}, 64'h22);
        check("rr_m1_grant", {62'd0, gs1}, 64'b10);

        // fixed priority: four writes from each master, M0 drains first
        begin
            int max0, min1;
            max0 = -1;
            min1 = 1 << 30;
            fork
                begin
                    int s; logic [1:0] r, gg;
                    for (int i = 0; i < 4; i++) begin
                        do_write(1, 0, 32'h20 + 4*i, 32'h100 + i, 0, 0, s, r, gg);
                        if (s > max0) max0 = s;
                    end
                end
                begin
                    int s; logic [1:0] r, gg;
                    for (int i = 0; i < 4; i++) begin
                        do_write(1, 1, 32'h40 + 4*i, 32'h200 + i, 0, 0, s, r, gg);
                        if (s < min1) min1 = s;
                    end
                end
            join
            check("fp_m0_before_m1", {63'd0, max0 < min1}, 64'd1);
            do_read(1, 1, 32'h44, d1, s1, gs1);
            check("fp_readback", {32'd0, d1}, 64'h201);
        end

        // M1 AW with W five cycles later; M0 must wait for M1's response
        aw0 = g_inst[0].aw_hs_cnt;
        fork
            do_write(0, 1, 32'h30, 32'h5A, 5, 0, s1, r1, gs1);
            begin
                repeat (2) @(posedge aclk);
                #1;
                do_write(0, 0, 32'h34, 32'h66, 0, 0, s0, r0, gs0);
            end
        join
        check("late_w_order", {63'd0, s1 < s0}, 64'd1);
        check("late_w_grant", {62'd0, gs1}, 64'b10);
        check("late_w_aw_count", g_inst[0].aw_hs_cnt - aw0, 64'd2);
        do_read(0, 0, 32'h30, d0, s0, gs0);
        check("late_w_data", {32'd0, d0}, 64'h5A);

        // M0 holds bready low; response must stay and M1 must not be granted
        fork
            do_write(0, 0, 32'h38, 32'h77, 0, 13, s0, r0, gs0);
            begin
                repeat (2) @(posedge aclk);
                #1;
                do_read(0, 1, 32'h14, d1, s1, gs1);
            end
            begin
                int w;
                w = 0;
                while (!bv[0][0] && w < 50) begin
                    @(negedge aclk);
                    w++;
                end
                check("bhold_seen", {63'd0, bv[0][0]}, 64'd1);
                repeat (5) begin
                    @(negedge aclk);
                    check("bhold_bv_grant", {60'd0, bv[0], grant[0]}, 64'b0101);
                end
            end
        join
        check("bhold_order", {63'd0, s0 < s1}, 64'd1);
        check("bhold_bresp", {62'd0, r0}, 64'd0);
        check("bhold_m1_data", {32'd0, d1}, 64'h22);

        // reset while the read response is being presented
        arv[0][0] = 1'b1;
        ara[0][0] = 32'h10;
        rry[0][0] = 1'b0;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge aclk);
            hs = arr[0][0];
            @(posedge aclk);
            #1;
            n++;
        end
        arv[0][0] = 1'b0;
        check("rst_ar_hs", {63'd0, hs}, 64'd1);
        n = 0;
        while (!rv[0][0] && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("rst_in_rresp", {60'd0, rv[0], grant[0]}, 64'b0101);
        check("rst_in_rdata", rdata[0], 64'h11);
        aresetn = 1'b0;
        #1;
        check_idle("midreset");
        @(negedge aclk);
        check_idle("midreset_cyc");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        do_read(0, 0, 32'h34, d0, s0, gs0);
        check("post_rst_data", {32'd0, d0}, 64'h66);
        check("post_rst_grant", {62'd0, gs0}, 64'b01);

        // EEPROM-style loop, masters alternating, readback by the other master
        for (int i = 0; i < 16; i++) begin
            do_write(0, i % 2, i, i + 32'hA0, 0, 0, s0, r0, gs0);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(0, (i + 1) % 2, i, d0, s0, gs0);
            check($sformatf("eeprom_%0h", i), {32'd0, d0}, 64'(i + 32'hA0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_axi_lite_arbiter.md
Name: i2c_axi_lite_arbiter

Overview:
- Two-master AXI-Lite arbiter that shares one i2c_axi_lite register port, e.g. between the CPU and a DMA/boot loader.
- Sits between the interconnect and the I2C controller's s_axi_* port.
- Grants one whole transaction at a time: one address, one data, one response.
- At most one transaction is outstanding downstream, so register sequences from the two masters never interleave within a transaction.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- FIXED_PRIO, 0: 0 = round-robin between masters; 1 = master 0 always wins.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- Upstream channels are packed per master: bit/field [i] belongs to master i, i = 0..1.
- s_axi_aw{addr,valid,ready}  in,in,out  2*ADDR_WIDTH,2,2  write address channel.
- s_axi_w{data,valid,ready}  in,in,out  2*DATA_WIDTH,2,2  write data channel.
- s_axi_b{resp,valid,ready}  out,out,in  4,2,2  write response channel.
- s_axi_ar{addr,valid,ready}  in,in,out  2*ADDR_WIDTH,2,2  read address channel.
- s_axi_r{data,resp,valid,ready}  out,out,out,in  2*DATA_WIDTH,4,2,2  read data channel.
- m_axi_aw{addr,valid,ready}  out,out,in  ADDR_WIDTH,1,1  to the I2C controller.
- m_axi_w{data,valid,ready}  out,out,in  DATA_WIDTH,1,1.
- m_axi_b{resp,valid,ready}  in,in,out  2,1,1.
- m_axi_ar{addr,valid,ready}  out,out,in  ADDR_WIDTH,1,1.
- m_axi_r{data,resp,valid,ready}  in,in,in,out  DATA_WIDTH,2,1,1.
- grant  out  2  one-hot current owner (debug/observability).

Behaviour:
- Reset: all valid/ready outputs, grant, rdata/resp outputs and last-grant pointer = 0; FSM in IDLE.
- req[i] = s_axi_awvalid[i] | s_axi_arvalid[i].
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP.
- IDLE:
  - If any req, pick winner: FIXED_PRIO=1 → lowest index; else round-robin, preferring the master not granted last.
  - Register grant, with one cycle of arbitration latency.
  - Winner with awvalid goes to WR_ADDR; otherwise it goes to RD_ADDR. Write beats read from the same master.
- WR_ADDR:
  - m_axi_aw* and m_axi_w* are driven from the granted master; other masters' ready is 0.
  - AW and W pass through combinationally: s_awready[g] = m_awready, s_wready[g] = m_wready.
  - AW and W may complete in either order or the same cycle; a per-channel done flag blocks re-forwarding.
  - Both done → WR_RESP.
- WR_RESP: m_bready = s_bready[g]; s_bvalid[g] = m_bvalid; bresp routed to [g]. Handshake → IDLE and update last-grant.
- RD_ADDR: m_arvalid = s_arvalid[g]; arready routed back. Handshake → RD_RESP.
- RD_RESP: rdata/rresp/rvalid routed to [g]; rready from [g]. Handshake → IDLE and update last-grant.
- Non-granted master: all of its ready/valid outputs are 0; its requests wait.
- No deadlock if a master raises AW before W: it holds the grant until W arrives.
- Back-to-back: IDLE is re-entered for at least one cycle between transactions, so minimum throughput is one transaction per 4 cycles with zero-wait slave.
- Simultaneous req from both masters in IDLE: exactly one is granted; the other is granted in the next IDLE under round-robin.
- Reset mid-transaction: immediate return to IDLE, all outputs cleared. Outstanding transactions are abandoned and the slave must also be reset (shares aresetn).
- Unused upstream data/resp lanes drive 0.

Test Plan:
- Reset, then M0 writes 0xA5 to addr 0x08 → m_awaddr=0x08, m_wdata=0xA5, s_bvalid[0] with bresp 0, s_bvalid[1] stays 0, grant 01→00.
- M0 and M1 raise arvalid in the same cycle, FIXED_PRIO=0, last-grant=M0 → M1 served first, then M0. Each receives its own rdata (0x11 / 0x22 from the slave model).
- FIXED_PRIO=1, both masters stream 4 writes each → all 4 M0 writes complete before any M1 write.
- M1 asserts AW, then W 5 cycles later; M0 requests meanwhile → M0 blocked until M1's B handshake. A single m_awvalid pulse is issued per transaction.
- Slave holds bvalid while s_bready[0] is held low for 10 cycles → bvalid stays, no new grant, no lost response.
- aresetn asserted in RD_RESP → next cycle all outputs 0, grant 00. After release, a new M0 read completes correctly.
- Integration: the existing EEPROM write/read loop over addresses 0x00–0x0F (data = addr+0xA0), driven from both masters alternately through the arbiter → every readback matches.
